// File: rtl/fifo_ctrl.sv
// FIFO pointer/flag controller driving a dual-port RAM with one-cycle registered read.
// Define FIFO_ERR_FLAGS_EN to add sticky oOverflow/oUnderflow outputs.
module fifo_ctrl #(
  parameter int ADDR_WIDTH       = 3,
  parameter int ALMOST_FULL_LVL  = 6,
  parameter int ALMOST_EMPTY_LVL = 1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iPush,
  input  logic                  iPop,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [ADDR_WIDTH-1:0] oReadAddress,
  output logic                  oDataValid,
  output logic                  oFull,
  output logic                  oEmpty,
  output logic                  oAlmostFull,
  output logic                  oAlmostEmpty,
  output logic [ADDR_WIDTH:0]   oCount
`ifdef FIFO_ERR_FLAGS_EN
  ,
  output logic                  oOverflow,
  output logic                  oUnderflow
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  valid_q;
  logic                  full_q, empty_q;
  logic                  afull_q, aempty_q;
  logic                  push_ok, pop_ok;

  always_comb begin
    pop_ok   = iPop & ~empty_q;
    // a full FIFO still takes a push when a pop frees the slot this cycle
    push_ok  = iPush & (~full_q | iPop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case (1'b1)
      push_ok & ~pop_ok: count_d = count_q + 1'b1;
      pop_ok & ~push_ok: count_d = count_q - 1'b1;
      default:           count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= pop_ok;
      full_q   <= int'(count_d) == DEPTH;
      empty_q  <= count_d == '0;
      afull_q  <= int'(count_d) >= ALMOST_FULL_LVL;
      aempty_q <= int'(count_d) <= ALMOST_EMPTY_LVL;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, unf_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (iPush & full_q & ~iPop) ovf_q <= 1'b1;
      if (iPop & empty_q)         unf_q <= 1'b1;
    end
  end

  assign oOverflow  = ovf_q;
  assign oUnderflow = unf_q;
`endif

  assign oWriteEnable  = push_ok;
  assign oWriteAddress = wr_ptr_q;
  assign oReadAddress  = rd_ptr_q;
  assign oDataValid    = valid_q;
  assign oFull         = full_q;
  assign oEmpty        = empty_q;
  assign oAlmostFull   = afull_q;
  assign oAlmostEmpty  = aempty_q;
  assign oCount        = count_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller that sits directly upstream of the dual-port memory and drives its write-enable, write-address and read-address inputs, turning the RAM into a synchronous FIFO.
- Accounts for the memory's one-cycle registered read: flags the cycle in which the RAM output holds valid popped data.
- Producer side uses push/full; consumer side uses pop/empty/valid.

Parameters:
- ADDR_WIDTH, 3, pointer width; FIFO depth = 2^ADDR_WIDTH (8 entries, matching memory MEM_SIZE 7). Memory address bits above ADDR_WIDTH are tied to 0 at integration.
- ALMOST_FULL_LVL, 6, oAlmostFull asserted when count >= this value.
- ALMOST_EMPTY_LVL, 1, oAlmostEmpty asserted when count <= this value.

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- iPush  input  1  producer write request; data is presented to the RAM iDataIn in the same cycle.
- iPop  input  1  consumer read request.
- oWriteEnable  output  1  to RAM iWriteEnable.
- oWriteAddress  output  ADDR_WIDTH  to RAM iWriteAddress.
- oReadAddress  output  ADDR_WIDTH  to RAM iReadAddress0.
- oDataValid  output  1  RAM oDataOut0 holds popped data this cycle.
- oFull  output  1  count == 2^ADDR_WIDTH.
- oEmpty  output  1  count == 0.
- oAlmostFull  output  1  count >= ALMOST_FULL_LVL.
- oAlmostEmpty  output  1  count <= ALMOST_EMPTY_LVL.
- oCount  output  ADDR_WIDTH+1  current occupancy.

Behaviour:
- Reset, asynchronous and active-high, clears all state immediately: wr_ptr=0, rd_ptr=0, count=0, oDataValid=0, oFull=0, oEmpty=1, oAlmostFull=0, oAlmostEmpty=1, oCount=0. Any push or pop in flight is discarded.
- oWriteAddress = wr_ptr and oReadAddress = rd_ptr, driven directly from the pointer registers (no combinational path from iPush/iPop).
- Push acceptance: push_ok = iPush & (~oFull | iPop).
  - Push while full is accepted only if a pop is accepted in the same cycle.
  - oWriteEnable = push_ok (combinational).
  - When push_ok, wr_ptr increments modulo 2^ADDR_WIDTH at the edge.
- Pop acceptance: pop_ok = iPop & ~oEmpty.
  - Pop while empty is ignored, including a simultaneous push; there is no fall-through.
  - When pop_ok, rd_ptr increments modulo 2^ADDR_WIDTH at the edge.
- Read latency is one cycle:
  - A pop accepted at edge N captures Ram[rd_ptr] into RAM oDataOut0 at the same edge.
  - oDataValid is registered as pop_ok, so it is 1 during the cycle following edge N.
- Full plus simultaneous push and pop: wr_ptr == rd_ptr, and the RAM returns the old word (read-before-write), so popped data is correct. Count is unchanged.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither. Count never exceeds 2^ADDR_WIDTH and never goes below 0.
- oFull, oEmpty, oAlmostFull and oAlmostEmpty are registered, computed from the next count value, so they are exact in the cycle after the causing edge.
- Pointer wrap: 7 -> 0 (default parameters) with no bubble.
- Push then pop on the next cycle returns the new word. The write commits at edge N; the read samples at edge N+1.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- With the macro defined:
  - Adds outputs oOverflow and oUnderflow.
  - oOverflow sets on iPush & oFull & ~iPop; oUnderflow sets on iPop & oEmpty.
  - Both are sticky until Reset and reset to 0.
  - Rejected requests still have no effect on pointers or count.
- Without the macro: the ports and logic are absent; rejected requests are silently dropped.

Test Plan:
- Reset asserted mid-stream with count=5 -> outputs return immediately, without a clock edge, to oCount=0, oEmpty=1, oFull=0, oDataValid=0, pointers 0.
- 8 consecutive pushes of 0x01..0x08 -> oCount 1..8; oAlmostFull=1 from count 6; oFull=1 after the 8th; a 9th push alone gives oWriteEnable=0 and count stays 8.
- Then 8 consecutive pops -> oDataValid=1 for 8 cycles, each one cycle after its pop, with RAM data 0x01..0x08 in order; oEmpty=1 at the end; a further pop gives oDataValid=0.
- Full FIFO with simultaneous push 0x2A and pop for 4 cycles -> count stays 8; popped data is the oldest entries; 0x2A entries emerge later in order across the 7->0 wrap.
- Empty FIFO with simultaneous push 0x15 and pop -> pop ignored, oDataValid=0, count=1; pop next cycle -> oDataValid=1 with data 0x15.
- With FIFO_ERR_FLAGS_EN: push on full without pop -> oOverflow=1 and stays set; pop on empty -> oUnderflow=1; both clear only on Reset.
